// File: rtl/gci_std_kmc_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// gci_std_kmc_ps2_rx_fifo
//  PS/2 device-to-host receiver: pin synchroniser, glitch filter, frame FSM
//  with bit watchdog, and a first-word fall-through scancode FIFO with a
//  valid/ready read port.
//
//  Read handshake: oRD_VALID is high whenever the FIFO holds an entry and
//  oRD_DATA then shows the oldest scancode; the entry is consumed on every
//  rising iCLOCK edge where oRD_VALID and iRD_READY are both high.
//  iRD_READY has no effect while oRD_VALID is low.
//
//  Optional feature macro: GCI_STD_KMC_PS2_PARITY_CHECK_EN
//   defined   : frames with even parity over D7..D0,P are dropped and
//               reported on oERR_PARITY.
//   undefined : the parity bit is clocked through but ignored, and
//               oERR_PARITY is held at 0.
// ---------------------------------------------------------------------------
module gci_std_kmc_ps2_rx_fifo #(
    parameter int P_FILTER_CYCLES  = 1250,
    parameter int P_TIMEOUT_CYCLES = 50000,
    parameter int P_FIFO_DEPTH     = 8,
    parameter int P_FIFO_AW        = 3
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iPS2_CLOCK,
    input  logic                 iPS2_DATA,
    output logic                 oRD_VALID,
    output logic [7:0]           oRD_DATA,
    input  logic                 iRD_READY,
    output logic [P_FIFO_AW:0]   oFIFO_COUNT,
    output logic                 oERR_PARITY,
    output logic                 oERR_FRAME,
    output logic                 oERR_TIMEOUT,
    output logic                 oERR_OVERFLOW
);

    localparam int LP_FILT_W = $clog2(P_FILTER_CYCLES + 1);
    localparam int LP_WDT_W  = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam logic [LP_FILT_W-1:0] LP_FILT_LAST = LP_FILT_W'(P_FILTER_CYCLES - 1);
    localparam logic [LP_WDT_W-1:0]  LP_WDT_LAST  = LP_WDT_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [P_FIFO_AW:0]   LP_FULL      = (P_FIFO_AW + 1)'(P_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rxState_t;

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic [1:0]           ps2ClockSync;
    logic [1:0]           ps2DataSync;
    logic                 clockFilt;
    logic                 dataFilt;
    logic                 clockFiltPrev;
    logic [LP_FILT_W-1:0] clockFiltCnt;
    logic [LP_FILT_W-1:0] dataFiltCnt;
    logic                 sampleEvent;

    // Two-flop synchronisers; both pins idle high so reset to 1.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            ps2ClockSync <= 2'b11;
            ps2DataSync  <= 2'b11;
        end else begin
            ps2ClockSync <= {ps2ClockSync[0], iPS2_CLOCK};
            ps2DataSync  <= {ps2DataSync[0], iPS2_DATA};
        end
    end

    // Clock filter: adopt the new level only after it has held for the full window.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            clockFilt    <= 1'b1;
            clockFiltCnt <= '0;
        end else if (ps2ClockSync[1] == clockFilt) begin
            clockFiltCnt <= '0;
        end else if (clockFiltCnt == LP_FILT_LAST) begin
            clockFilt    <= ps2ClockSync[1];
            clockFiltCnt <= '0;
        end else begin
            clockFiltCnt <= clockFiltCnt + 1'b1;
        end
    end

    // Data filter: same scheme as the clock filter.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            dataFilt    <= 1'b1;
            dataFiltCnt <= '0;
        end else if (ps2DataSync[1] == dataFilt) begin
            dataFiltCnt <= '0;
        end else if (dataFiltCnt == LP_FILT_LAST) begin
            dataFilt    <= ps2DataSync[1];
            dataFiltCnt <= '0;
        end else begin
            dataFiltCnt <= dataFiltCnt + 1'b1;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            clockFiltPrev <= 1'b1;
        end else begin
            clockFiltPrev <= clockFilt;
        end
    end

    assign sampleEvent = clockFiltPrev & ~clockFilt;

    // ------------------------------------------------------------------
    // Frame FSM and watchdog
    // ------------------------------------------------------------------
    rxState_t            state;
    logic [2:0]          bitCnt;
    logic [7:0]          shiftReg;
    logic [LP_WDT_W-1:0] wdtCnt;
    logic                timeoutHit;
    logic                parityGood;
    logic                pushReq;
    logic [7:0]          pushData;
    logic                errFrame;
    logic                errTimeout;

`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
    logic                parityBit;
    logic                errParity;
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign parityGood  = ^{shiftReg, parityBit};
    assign oERR_PARITY = errParity;
`else
    assign parityGood  = 1'b1;
    assign oERR_PARITY = 1'b0;
`endif

    // The watchdog fires on the last allowed cycle and wins over a coincident sample.
    assign timeoutHit = (state != ST_IDLE) && (wdtCnt == LP_WDT_LAST);

    // Frame receiver: advances on sample events, aborted by the watchdog.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state      <= ST_IDLE;
            bitCnt     <= 3'd0;
            shiftReg   <= 8'h00;
            wdtCnt     <= '0;
            pushReq    <= 1'b0;
            pushData   <= 8'h00;
            errFrame   <= 1'b0;
            errTimeout <= 1'b0;
`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
            parityBit  <= 1'b0;
            errParity  <= 1'b0;
`endif
        end else begin
            pushReq    <= 1'b0;
            errFrame   <= 1'b0;
            errTimeout <= 1'b0;
`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
            errParity  <= 1'b0;
`endif
            if (timeoutHit) begin
                state      <= ST_IDLE;
                wdtCnt     <= '0;
                errTimeout <= 1'b1;
            end else if (sampleEvent) begin
                wdtCnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!dataFilt) begin
                            state  <= ST_DATA;
                            bitCnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shiftReg[bitCnt] <= dataFilt;
                        bitCnt           <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
                        parityBit <= dataFilt;
`endif
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!dataFilt) begin
                            errFrame <= 1'b1;
                        end else if (parityGood) begin
                            pushReq  <= 1'b1;
                            pushData <= shiftReg;
                        end else begin
`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
                            errParity <= 1'b1;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                wdtCnt <= wdtCnt + 1'b1;
            end else begin
                wdtCnt <= '0;
            end
        end
    end

    assign oERR_FRAME   = errFrame;
    assign oERR_TIMEOUT = errTimeout;

    // ------------------------------------------------------------------
    // Scancode FIFO
    // ------------------------------------------------------------------
    logic [7:0]           fifoMem [P_FIFO_DEPTH];
    logic [P_FIFO_AW-1:0] wrPtr;
    logic [P_FIFO_AW-1:0] rdPtr;
    logic [P_FIFO_AW:0]   fifoCount;
    logic                 errOverflow;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic                 doPop;
    logic                 doPush;

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == LP_FULL);
    assign doPop     = !fifoEmpty && iRD_READY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush    = pushReq && (!fifoFull || doPop);

    // Storage array; contents are never visible while empty, so no reset needed.
    always_ff @(posedge iCLOCK) begin
        if (doPush) begin
            fifoMem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy and overflow pulse.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            fifoCount   <= '0;
            errOverflow <= 1'b0;
        end else begin
            errOverflow <= pushReq && !doPush;
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (doPop && !doPush) begin
                fifoCount <= fifoCount - 1'b1;
            end
        end
    end

    assign oRD_VALID     = !fifoEmpty;
    assign oRD_DATA      = fifoEmpty ? 8'h00 : fifoMem[rdPtr];
    assign oFIFO_COUNT   = fifoCount;
    assign oERR_OVERFLOW = errOverflow;

endmodule

// File: tb/tb_gci_std_kmc_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_gci_std_kmc_ps2_rx_fifo
//  Directed bench for the PS/2 receiver FIFO. Short filter/timeout
//  parameters keep frames to a few hundred cycles. A table of single
//  frames covers data/parity/stop combinations; hand-written sequences
//  cover watchdog abort, FIFO overflow and drain order, glitch rejection
//  and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_gci_std_kmc_ps2_rx_fifo;

    localparam int FILT  = 4;
    localparam int TOUT  = 200;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    // Clock/reset and DUT signals
    logic          iCLOCK = 1'b0;
    logic          inRESET = 1'b0;
    logic          ps2Clock = 1'b1;
    logic          ps2Data = 1'b1;
    logic          rdReady = 1'b0;
    logic          rdValid;
    logic [7:0]    rdData;
    logic [AW:0]   fifoCount;
    logic          errParity;
    logic          errFrame;
    logic          errTimeout;
    logic          errOverflow;

    always #5 iCLOCK = ~iCLOCK;

    gci_std_kmc_ps2_rx_fifo #(
        .P_FILTER_CYCLES (FILT),
        .P_TIMEOUT_CYCLES(TOUT),
        .P_FIFO_DEPTH    (DEPTH),
        .P_FIFO_AW       (AW)
    ) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iPS2_CLOCK   (ps2Clock),
        .iPS2_DATA    (ps2Data),
        .oRD_VALID    (rdValid),
        .oRD_DATA     (rdData),
        .iRD_READY    (rdReady),
        .oFIFO_COUNT  (fifoCount),
        .oERR_PARITY  (errParity),
        .oERR_FRAME   (errFrame),
        .oERR_TIMEOUT (errTimeout),
        .oERR_OVERFLOW(errOverflow)
    );

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    int nFrame = 0;
    int nParity = 0;
    int nTimeout = 0;
    int nOverflow = 0;
    logic [7:0] exp_q[$];

    // Error pulse counters, sampled on the falling edge
    always @(negedge iCLOCK) begin
        if (errFrame)    nFrame++;
        if (errParity)   nParity++;
        if (errTimeout)  nTimeout++;
        if (errOverflow) nOverflow++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Driver: one PS/2 bit, data set mid-high phase, 20-cycle low phase
    task automatic send_bit(input logic b);
        ps2Data = b;
        repeat (10) @(negedge iCLOCK);
        ps2Clock = 1'b0;
        repeat (20) @(negedge iCLOCK);
        ps2Clock = 1'b1;
        repeat (10) @(negedge iCLOCK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic parFlip, input logic stopBit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ parFlip);
        send_bit(stopBit);
        ps2Data = 1'b1;
        repeat (20) @(negedge iCLOCK);
    endtask

    task automatic pop_one();
        @(negedge iCLOCK);
        rdReady = 1'b1;
        @(negedge iCLOCK);
        rdReady = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       parFlip;
        logic       stopBit;
        logic       expStore;
        int         expFrame;
        int         expParity;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int f0, p0, t0, o0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0, 0};
`ifdef GCI_STD_KMC_PS2_PARITY_CHECK_EN
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 0, 1};
`else
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 0, 0};
`endif
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[6] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1, 0};
        vecs[7] = '{8'h83, 1'b0, 1'b1, 1'b1, 0, 0};

        // Reset state
        repeat (3) @(negedge iCLOCK);
        check("reset_count", 32'(fifoCount), 0);
        check("reset_valid", 32'(rdValid), 0);
        check("reset_data", 32'(rdData), 0);
        check("reset_errs", {errParity, errFrame, errTimeout, errOverflow}, 0);
        inRESET = 1'b1;
        repeat (5) @(negedge iCLOCK);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            f0 = nFrame; p0 = nParity; t0 = nTimeout; o0 = nOverflow;
            send_frame(vecs[v].data, vecs[v].parFlip, vecs[v].stopBit);
            check($sformatf("vec%0d_count", v), 32'(fifoCount), 32'(vecs[v].expStore));
            check($sformatf("vec%0d_valid", v), 32'(rdValid), 32'(vecs[v].expStore));
            if (vecs[v].expStore) check($sformatf("vec%0d_data", v), 32'(rdData), 32'(vecs[v].data));
            check($sformatf("vec%0d_frame_err", v), nFrame - f0, vecs[v].expFrame);
            check($sformatf("vec%0d_parity_err", v), nParity - p0, vecs[v].expParity);
            check($sformatf("vec%0d_timeout_err", v), nTimeout - t0, 0);
            check($sformatf("vec%0d_overflow_err", v), nOverflow - o0, 0);
            if (vecs[v].expStore) begin
                pop_one();
                check($sformatf("vec%0d_count_after_pop", v), 32'(fifoCount), 0);
            end
        end

        // Watchdog: clock stops after D3, then a normal frame follows
        f0 = nFrame; t0 = nTimeout;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2Data = 1'b1;
        repeat (TOUT + 100) @(negedge iCLOCK);
        check("timeout_pulses", nTimeout - t0, 1);
        check("timeout_count", 32'(fifoCount), 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("after_timeout_data", 32'(rdData), 32'h29);
        check("after_timeout_count", 32'(fifoCount), 1);
        check("after_timeout_frame_err", nFrame - f0, 0);
        pop_one();

        // Overflow: nine frames with the reader stalled, then drain in order
        o0 = nOverflow;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b0, 1'b1);
            if (i <= DEPTH) exp_q.push_back(8'(i));
        end
        check("full_count", 32'(fifoCount), DEPTH);
        check("full_overflow", nOverflow - o0, 1);
        check("full_valid", 32'(rdValid), 1);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check($sformatf("drain_%0h", e), 32'(rdData), 32'(e));
            pop_one();
        end
        check("drained_count", 32'(fifoCount), 0);
        check("drained_valid", 32'(rdValid), 0);

        // Glitches shorter than the filter window on both pins
        f0 = nFrame; t0 = nTimeout;
        ps2Data = 1'b0;
        repeat (20) @(negedge iCLOCK);
        for (int g = 0; g < 4; g++) begin
            ps2Clock = 1'b0;
            repeat (3) @(negedge iCLOCK);
            ps2Clock = 1'b1;
            @(negedge iCLOCK);
        end
        repeat (10) @(negedge iCLOCK);
        ps2Data = 1'b1;
        repeat (10) @(negedge iCLOCK);
        for (int g = 0; g < 4; g++) begin
            ps2Data = 1'b0;
            repeat (3) @(negedge iCLOCK);
            ps2Data = 1'b1;
            @(negedge iCLOCK);
        end
        repeat (TOUT + 50) @(negedge iCLOCK);
        check("glitch_timeout", nTimeout - t0, 0);
        check("glitch_count", 32'(fifoCount), 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        check("after_glitch_data", 32'(rdData), 32'h3C);
        check("after_glitch_frame_err", nFrame - f0, 0);
        check("after_glitch_count", 32'(fifoCount), 1);

        // Reset mid-frame with an entry already stored
        send_frame(8'h77, 1'b0, 1'b1);
        check("pre_reset_count", 32'(fifoCount), 2);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2Data = 1'b1;
        inRESET = 1'b0;
        repeat (2) @(negedge iCLOCK);
        check("midreset_count", 32'(fifoCount), 0);
        check("midreset_valid", 32'(rdValid), 0);
        check("midreset_data", 32'(rdData), 0);
        check("midreset_errs", {errParity, errFrame, errTimeout, errOverflow}, 0);
        inRESET = 1'b1;
        repeat (5) @(negedge iCLOCK);
        f0 = nFrame; t0 = nTimeout;
        send_frame(8'h12, 1'b0, 1'b1);
        check("after_reset_data", 32'(rdData), 32'h12);
        check("after_reset_count", 32'(fifoCount), 1);
        check("after_reset_errs", (nFrame - f0) + (nTimeout - t0), 0);
        pop_one();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
